// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the stream-to-memory program loader.
package punc_loader_pkg;

    localparam int unsigned STATE_WIDTH = 3;
    localparam int unsigned HDR_WORDS   = 2;
    localparam int unsigned CSUM_WIDTH  = 16;

    typedef enum logic [STATE_WIDTH-1:0] {
        IDLE     = 3'd0,
        HDR_ADDR = 3'd1,
        HDR_LEN  = 3'd2,
        DATA     = 3'd3,
        CSUM     = 3'd4,
        FIN      = 3'd5
    } state_t;

    // States in which the loader accepts a stream word.
    function automatic logic is_accepting(input state_t s, input logic csum_en);
        return (s == HDR_ADDR) || (s == HDR_LEN) || (s == DATA) || (csum_en && (s == CSUM));
    endfunction

endpackage

// File: rtl/mem_loader_csum.sv
// Modulo-2^DATA_WIDTH running sum with clear, add-enable and equality compare.
module mem_loader_csum
    import punc_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CSUM_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  logic                  i_add,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [DATA_WIDTH-1:0] i_cmp,
    output logic                  o_match_c
);

    logic [DATA_WIDTH-1:0] r_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (i_clr) begin
            r_sum <= '0;
        end else if (i_add) begin
            r_sum <= r_sum + i_data;
        end
    end

    assign o_match_c = (r_sum == i_cmp);

endmodule

// File: rtl/mem_loader.sv
// Framed stream to program-memory write loader; holds the core busy while loading.
// Define MEM_LOADER_CHECKSUM_EN to consume and verify a trailing checksum word.
module mem_loader
    import punc_loader_pkg::*;
#(
    parameter int unsigned N_ELEMENTS = 128,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_en,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] words_written
);

`ifdef MEM_LOADER_CHECKSUM_EN
    localparam logic   CSUM_EN    = 1'b1;
    localparam state_t AFTER_DATA = CSUM;
`else
    localparam logic   CSUM_EN    = 1'b0;
    localparam state_t AFTER_DATA = FIN;
`endif

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_in_ready;
    logic [ADDR_WIDTH-1:0] r_w_addr;
    logic [DATA_WIDTH-1:0] r_w_data;
    logic                  r_w_en;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_words_written;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [DATA_WIDTH-1:0] r_len;
    logic [DATA_WIDTH-1:0] r_idx;

    logic                  w_xfer;
    logic                  w_start;
    logic                  w_ld_base;
    logic                  w_ld_len;
    logic                  w_data_xfer;
    logic                  w_csum_xfer;
    logic                  w_csum_match;
    logic [DATA_WIDTH-1:0] w_idx_nxt;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic                  w_in_range;

    assign w_xfer     = in_valid & r_in_ready;
    assign w_idx_nxt  = r_idx + DATA_WIDTH'(1);
    assign w_wr_addr  = r_base + ADDR_WIDTH'(r_idx);
    assign w_in_range = (32'(w_wr_addr) < 32'(N_ELEMENTS));

`ifdef MEM_LOADER_CHECKSUM_EN
    mem_loader_csum #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_csum (
        .clk       (clk),
        .rst_n     (rst),
        .i_clr     (w_ld_len),
        .i_add     (w_data_xfer),
        .i_data    (in_data),
        .i_cmp     (in_data),
        .o_match_c (w_csum_match)
    );
`else
    assign w_csum_match = 1'b1;
`endif

    // Next-state and per-cycle control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_ld_base   = 1'b0;
        w_ld_len    = 1'b0;
        w_data_xfer = 1'b0;
        w_csum_xfer = 1'b0;
        case (r_state)
            IDLE: begin
                if (load_en) begin
                    w_start     = 1'b1;
                    w_state_nxt = HDR_ADDR;
                end
            end
            HDR_ADDR: begin
                if (w_xfer) begin
                    w_ld_base   = 1'b1;
                    w_state_nxt = HDR_LEN;
                end
            end
            HDR_LEN: begin
                if (w_xfer) begin
                    w_ld_len    = 1'b1;
                    w_state_nxt = (in_data == '0) ? AFTER_DATA : DATA;
                end
            end
            DATA: begin
                if (w_xfer) begin
                    w_data_xfer = 1'b1;
                    if (w_idx_nxt == r_len) begin
                        w_state_nxt = AFTER_DATA;
                    end
                end
            end
            CSUM: begin
                if (!CSUM_EN) begin
                    w_state_nxt = FIN;
                end else if (w_xfer) begin
                    w_csum_xfer = 1'b1;
                    w_state_nxt = FIN;
                end
            end
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= IDLE;
            r_in_ready      <= 1'b0;
            r_w_addr        <= '0;
            r_w_data        <= '0;
            r_w_en          <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_err           <= 1'b0;
            r_words_written <= '0;
            r_base          <= '0;
            r_len           <= '0;
            r_idx           <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= is_accepting(w_state_nxt, CSUM_EN);
            r_busy     <= (w_state_nxt != IDLE) && (w_state_nxt != FIN);
            r_done     <= (w_state_nxt == FIN);
            r_w_en     <= 1'b0;
            if (w_start) begin
                r_err           <= 1'b0;
                r_words_written <= '0;
            end
            if (w_ld_base) begin
                r_base <= ADDR_WIDTH'(in_data);
            end
            if (w_ld_len) begin
                r_len <= in_data;
                r_idx <= '0;
            end
            if (w_data_xfer) begin
                r_idx <= w_idx_nxt;
                if (w_in_range) begin
                    r_w_en          <= 1'b1;
                    r_w_addr        <= w_wr_addr;
                    r_w_data        <= in_data;
                    r_words_written <= r_words_written + ADDR_WIDTH'(1);
                end else begin
                    r_err <= 1'b1;
                end
            end
            if (w_csum_xfer && !w_csum_match) begin
                r_err <= 1'b1;
            end
        end
    end

    assign in_ready      = r_in_ready;
    assign w_addr        = r_w_addr;
    assign w_data        = r_w_data;
    assign w_en          = r_w_en;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign words_written = r_words_written;

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: directed frames, expected writes/frame ends queued at issue time.
module tb_mem_loader;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned NE = 128;
`ifdef MEM_LOADER_CHECKSUM_EN
    localparam logic CSUM_ON = 1'b1;
`else
    localparam logic CSUM_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_en = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          w_en;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] words_written;

    mem_loader #(
        .N_ELEMENTS (NE),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load_en       (load_en),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .w_addr        (w_addr),
        .w_data        (w_data),
        .w_en          (w_en),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int cyc; } wr_t;
    typedef struct { logic err; logic [AW-1:0] words; } done_t;
    wr_t   wr_q[$];
    done_t done_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every w_en and done pulse must match the head of its queue.
    always @(negedge clk) begin
        wr_t   e;
        done_t d;
        if (rst) begin
            if (w_en) begin
                if (wr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_wen: got addr 0x%0h data 0x%0h, none expected", w_addr, w_data);
                end else begin
                    e = wr_q.pop_front();
                    chk("w_addr", 32'(w_addr), 32'(e.addr));
                    chk("w_data", 32'(w_data), 32'(e.data));
                    chk("w_en_latency", cyc, e.cyc);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1, none expected");
                end else begin
                    d = done_q.pop_front();
                    chk("err_at_done", 32'(err), 32'(d.err));
                    chk("words_written", 32'(words_written), 32'(d.words));
                    chk("busy_at_done", 32'(busy), 32'd0);
                end
            end
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one word and hold it until transferred; xcyc = cycle index of the transfer edge.
    task automatic send(input logic [DW-1:0] d, output int xcyc);
        int n = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("send_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        xcyc     = cyc;
        in_valid = 1'b0;
    endtask

    task automatic start_frame();
        load_en = 1'b1;
        @(posedge clk);
        #1;
        load_en = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic frame(input logic [AW-1:0] base, input logic [DW-1:0] len,
                         input logic [DW-1:0] d [4], input logic [DW-1:0] csum,
                         input int gap, input logic exp_err, input logic [AW-1:0] exp_words);
        int            xc;
        int            n;
        logic [AW-1:0] a;
        done_t         de;
        de.err   = exp_err;
        de.words = exp_words;
        done_q.push_back(de);
        start_frame();
        send(base, xc);
        send(len, xc);
        for (int i = 0; i < int'(len); i++) begin
            send(d[i], xc);
            a = base + AW'(i);
            if (32'(a) < 32'(NE)) wr_q.push_back('{a, d[i], xc});
            if (i == 0 && gap > 0) idle(gap);
        end
        if (CSUM_ON) send(csum, xc);
        n = 0;
        while (busy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("frame_end_timeout", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_w_en"}, 32'(w_en), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_w_addr"}, 32'(w_addr), 32'd0);
        chk({tag, "_w_data"}, 32'(w_data), 32'd0);
        chk({tag, "_words_written"}, 32'(words_written), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int xc;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b1;
        idle(2);

        // Basic load: 0x2012+0x2212+0xF000 = 0x3224 (mod 2^16).
        frame(16'h0000, 16'd3, '{16'h2012, 16'h2212, 16'hF000, 16'h0000}, 16'h3224, 0, 1'b0, 16'd3);
        // Wrong checksum: writes still happen, err only when the checksum is checked.
        frame(16'h0000, 16'd3, '{16'h2012, 16'h2212, 16'hF000, 16'h0000}, 16'h3225, 0, CSUM_ON, 16'd3);
        // Bubbles: valid 1,0,0,1; err from previous frame must clear.
        frame(16'h0010, 16'd2, '{16'hAAAA, 16'h5555, 16'h0000, 16'h0000}, 16'hFFFF, 2, 1'b0, 16'd2);
        // Out of range: only 0x7E and 0x7F are written.
        frame(16'h007E, 16'd4, '{16'h1111, 16'h2222, 16'h3333, 16'h4444}, 16'hAAAA, 0, 1'b1, 16'd2);

        // load_en gating: no handshake while idle.
        in_data  = 16'h1234;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("idle_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;

        // len=0: no writes, done still pulses.
        frame(16'h0005, 16'd0, '{16'h0, 16'h0, 16'h0, 16'h0}, 16'h0000, 0, 1'b0, 16'd0);

        // Reset after the first data transfer of a 4-word frame.
        start_frame();
        send(16'h0020, xc);
        send(16'd4, xc);
        send(16'h0BAD, xc);
        chk("pre_rst_w_en", 32'(w_en), 32'd1);
        chk("pre_rst_w_addr", 32'(w_addr), 32'h20);
        chk("pre_rst_words", 32'(words_written), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);
        chk("post_rst_in_ready", 32'(in_ready), 32'd0);

        // Full frame after reset: sum 1+2+3+4 = 0x000A.
        frame(16'h0020, 16'd4, '{16'h0001, 16'h0002, 16'h0003, 16'h0004}, 16'h000A, 0, 1'b0, 16'd4);

        idle(5);
        chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
        chk("done_q_drained", 32'(done_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
